// File: rtl/alu_issue_wb_if.sv
// Handshake bundle for alu_issue_wb: issue, register load, ALU hookup, result.
// Status flag signals exist only when ALU_STATUS_FLAGS_EN is defined.
interface alu_issue_wb_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 3
);
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        in_op;
    logic [ADDR_W-1:0] in_rd;
    logic [ADDR_W-1:0] in_rs1;
    logic [ADDR_W-1:0] in_rs2;
    logic              ld_valid;
    logic [ADDR_W-1:0] ld_addr;
    logic [DATA_W-1:0] ld_data;
    logic [2:0]        alu_op;
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [DATA_W-1:0] alu_y;
    logic              res_valid;
    logic              res_ready;
    logic [DATA_W-1:0] res_data;
    logic [ADDR_W-1:0] res_rd;
`ifdef ALU_STATUS_FLAGS_EN
    logic              res_zero;
    logic              res_neg;
`endif

    modport master (
        output in_valid, in_op, in_rd, in_rs1, in_rs2,
        output ld_valid, ld_addr, ld_data,
        output alu_y, res_ready,
        input  in_ready, alu_op, alu_a, alu_b,
`ifdef ALU_STATUS_FLAGS_EN
        input  res_zero, res_neg,
`endif
        input  res_valid, res_data, res_rd
    );

    modport slave (
        input  in_valid, in_op, in_rd, in_rs1, in_rs2,
        input  ld_valid, ld_addr, ld_data,
        input  alu_y, res_ready,
        output in_ready, alu_op, alu_a, alu_b,
`ifdef ALU_STATUS_FLAGS_EN
        output res_zero, res_neg,
`endif
        output res_valid, res_data, res_rd
    );
endinterface

// File: rtl/alu_issue_wb.sv
// Non-pipelined issue/writeback stage around an external combinational ALU.
// Optional ALU_STATUS_FLAGS_EN adds registered res_zero/res_neg outputs.
module alu_issue_wb #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    alu_issue_wb_if.slave bus
);
    localparam int NREG = 1 << ADDR_W;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [DATA_W-1:0] rf_q [NREG];
    logic [2:0]        alu_op_q, alu_op_d;
    logic [DATA_W-1:0] alu_a_q, alu_a_d;
    logic [DATA_W-1:0] alu_b_q, alu_b_d;
    logic [DATA_W-1:0] res_data_q, res_data_d;
    logic [ADDR_W-1:0] res_rd_q, res_rd_d;
    logic              res_valid_q, res_valid_d;
`ifdef ALU_STATUS_FLAGS_EN
    logic              zero_q, zero_d;
    logic              neg_q, neg_d;
`endif

    logic              rf_we;
    logic [ADDR_W-1:0] rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
    logic [DATA_W-1:0] rs1_val, rs2_val;

    assign rs1_val = (bus.in_rs1 == '0) ? '0 : rf_q[bus.in_rs1];
    assign rs2_val = (bus.in_rs2 == '0) ? '0 : rf_q[bus.in_rs2];

    always_comb begin
        state_d     = state_q;
        alu_op_d    = alu_op_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        res_data_d  = res_data_q;
        res_rd_d    = res_rd_q;
        res_valid_d = res_valid_q;
`ifdef ALU_STATUS_FLAGS_EN
        zero_d      = zero_q;
        neg_d       = neg_q;
`endif
        rf_we       = 1'b0;
        rf_waddr    = bus.ld_addr;
        rf_wdata    = bus.ld_data;
        unique case (state_q)
            IDLE: begin
                if (bus.ld_valid) begin
                    rf_we = 1'b1;
                end else if (bus.in_valid) begin
                    alu_op_d = bus.in_op;
                    alu_a_d  = rs1_val;
                    alu_b_d  = rs2_val;
                    res_rd_d = bus.in_rd;
                    state_d  = EXEC;
                end
            end
            EXEC: begin
                res_data_d  = bus.alu_y;
                rf_we       = 1'b1;
                rf_waddr    = res_rd_q;
                rf_wdata    = bus.alu_y;
                res_valid_d = 1'b1;
`ifdef ALU_STATUS_FLAGS_EN
                zero_d      = (bus.alu_y == '0);
                neg_d       = bus.alu_y[DATA_W-1];
`endif
                state_d     = DONE;
            end
            DONE: begin
                if (bus.res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            alu_op_q    <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            res_data_q  <= '0;
            res_rd_q    <= '0;
            res_valid_q <= 1'b0;
`ifdef ALU_STATUS_FLAGS_EN
            zero_q      <= 1'b0;
            neg_q       <= 1'b0;
`endif
            for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            alu_op_q    <= alu_op_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            res_data_q  <= res_data_d;
            res_rd_q    <= res_rd_d;
            res_valid_q <= res_valid_d;
`ifdef ALU_STATUS_FLAGS_EN
            zero_q      <= zero_d;
            neg_q       <= neg_d;
`endif
            // r0 is hardwired to zero, so its writes are dropped here
            if (rf_we && rf_waddr != '0) rf_q[rf_waddr] <= rf_wdata;
        end
    end

    assign bus.in_ready  = (state_q == IDLE) && !bus.ld_valid;
    assign bus.alu_op    = alu_op_q;
    assign bus.alu_a     = alu_a_q;
    assign bus.alu_b     = alu_b_q;
    assign bus.res_data  = res_data_q;
    assign bus.res_rd    = res_rd_q;
    assign bus.res_valid = res_valid_q;
`ifdef ALU_STATUS_FLAGS_EN
    assign bus.res_zero  = zero_q;
    assign bus.res_neg   = neg_q;
`endif
endmodule

// File: tb/tb_alu_issue_wb.sv
// Directed bench for alu_issue_wb with a small reference ALU attached.
// Covers latency, hazards, r0, stall, load priority and mid-flight reset.
module tb_alu_issue_wb;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    alu_issue_wb_if #(.DATA_W(32), .ADDR_W(3)) bus ();

    alu_issue_wb #(.DATA_W(32), .ADDR_W(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // reference ALU: 000 pass A, 001 add, 010 sub, 011 and, 100 or, 101 xor
    always_comb begin
        bus.alu_y = '0;
        case (bus.alu_op)
            3'b000: bus.alu_y = bus.alu_a;
            3'b001: bus.alu_y = bus.alu_a + bus.alu_b;
            3'b010: bus.alu_y = bus.alu_a - bus.alu_b;
            3'b011: bus.alu_y = bus.alu_a & bus.alu_b;
            3'b100: bus.alu_y = bus.alu_a | bus.alu_b;
            3'b101: bus.alu_y = bus.alu_a ^ bus.alu_b;
            3'b110: bus.alu_y = bus.alu_a << bus.alu_b[4:0];
            default: bus.alu_y = ~bus.alu_a;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [2:0] a, input logic [31:0] d);
        bus.ld_valid = 1'b1;
        bus.ld_addr  = a;
        bus.ld_data  = d;
        tick();
        bus.ld_valid = 1'b0;
    endtask

    task automatic issue(input logic [2:0] op, input logic [2:0] rd,
                         input logic [2:0] rs1, input logic [2:0] rs2);
        bus.in_op  = op;
        bus.in_rd  = rd;
        bus.in_rs1 = rs1;
        bus.in_rs2 = rs2;
        bus.in_valid = 1'b1;
        #1;
        check("in_ready_idle", 32'(bus.in_ready), 32'd1);
        tick();
        bus.in_valid = 1'b0;
        check("exec_no_valid", 32'(bus.res_valid), 32'd0);
    endtask

    task automatic run(input string tag, input logic [2:0] op,
                       input logic [2:0] rd, input logic [2:0] rs1,
                       input logic [2:0] rs2, input logic [31:0] exp);
        issue(op, rd, rs1, rs2);
        tick();
        check({tag, "_valid"}, 32'(bus.res_valid), 32'd1);
        check({tag, "_data"}, bus.res_data, exp);
        check({tag, "_rd"}, 32'(bus.res_rd), 32'(rd));
`ifdef ALU_STATUS_FLAGS_EN
        check({tag, "_zero"}, 32'(bus.res_zero), 32'(exp == 32'd0));
        check({tag, "_neg"}, 32'(bus.res_neg), 32'(exp[31]));
`endif
        bus.res_ready = 1'b1;
        tick();
        bus.res_ready = 1'b0;
        check({tag, "_drain"}, 32'(bus.res_valid), 32'd0);
        check({tag, "_idle"}, 32'(bus.in_ready), 32'd1);
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_op     = '0;
        bus.in_rd     = '0;
        bus.in_rs1    = '0;
        bus.in_rs2    = '0;
        bus.ld_valid  = 1'b0;
        bus.ld_addr   = '0;
        bus.ld_data   = '0;
        bus.res_ready = 1'b0;

        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        check("rst_valid", 32'(bus.res_valid), 32'd0);
        check("rst_ready", 32'(bus.in_ready), 32'd1);
        check("rst_data", bus.res_data, 32'd0);
        check("rst_rd", 32'(bus.res_rd), 32'd0);
        check("rst_op", 32'(bus.alu_op), 32'd0);
        check("rst_a", bus.alu_a, 32'd0);
        check("rst_b", bus.alu_b, 32'd0);

        load(3'd1, 32'd5);
        load(3'd2, 32'd3);
        run("add", 3'b001, 3'd3, 3'd1, 3'd2, 32'd8);
        run("dep", 3'b000, 3'd7, 3'd3, 3'd0, 32'd8);
        run("same_src", 3'b001, 3'd5, 3'd1, 3'd1, 32'd10);
        run("rd_is_src", 3'b001, 3'd1, 3'd1, 3'd2, 32'd8);
        run("rd_new", 3'b000, 3'd0, 3'd1, 3'd0, 32'd8);

        load(3'd1, 32'd3);
        load(3'd2, 32'd5);
        run("sub", 3'b010, 3'd4, 3'd1, 3'd2, 32'hFFFF_FFFE);
        run("sub_rb", 3'b000, 3'd0, 3'd4, 3'd0, 32'hFFFF_FFFE);
        run("xor", 3'b101, 3'd6, 3'd1, 3'd1, 32'd0);

        load(3'd0, 32'h1234);
        run("r0_load", 3'b000, 3'd0, 3'd0, 3'd0, 32'd0);
        run("r0_wb", 3'b001, 3'd0, 3'd1, 3'd2, 32'd8);
        run("r0_read", 3'b000, 3'd5, 3'd0, 3'd0, 32'd0);

        // hold the result while a competing instruction is offered
        issue(3'b001, 3'd5, 3'd1, 3'd2);
        tick();
        bus.in_op    = 3'b011;
        bus.in_rd    = 3'd6;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("stall_valid", 32'(bus.res_valid), 32'd1);
            check("stall_data", bus.res_data, 32'd8);
            check("stall_rd", 32'(bus.res_rd), 32'd5);
            check("stall_ready", 32'(bus.in_ready), 32'd0);
            tick();
        end
        bus.in_valid  = 1'b0;
        check("stall_op", 32'(bus.alu_op), 32'd1);
        bus.res_ready = 1'b1;
        tick();
        bus.res_ready = 1'b0;
        check("stall_exit_valid", 32'(bus.res_valid), 32'd0);
        check("stall_exit_ready", 32'(bus.in_ready), 32'd1);
        run("stall_wb", 3'b000, 3'd0, 3'd5, 3'd0, 32'd8);

        // load and issue in the same cycle: load wins
        bus.ld_valid = 1'b1;
        bus.ld_addr  = 3'd6;
        bus.ld_data  = 32'h77;
        bus.in_op    = 3'b000;
        bus.in_rd    = 3'd7;
        bus.in_rs1   = 3'd6;
        bus.in_rs2   = 3'd0;
        bus.in_valid = 1'b1;
        #1;
        check("ldpri_ready", 32'(bus.in_ready), 32'd0);
        tick();
        bus.ld_valid = 1'b0;
        #1;
        check("ldpri_noacc", 32'(bus.res_valid), 32'd0);
        check("ldpri_ready2", 32'(bus.in_ready), 32'd1);
        tick();
        bus.in_valid = 1'b0;
        check("ldpri_a", bus.alu_a, 32'h77);
        tick();
        check("ldpri_valid", 32'(bus.res_valid), 32'd1);
        check("ldpri_data", bus.res_data, 32'h77);
        bus.res_ready = 1'b1;
        tick();
        bus.res_ready = 1'b0;

        // reset while the instruction is in EXEC
        load(3'd1, 32'd5);
        load(3'd2, 32'd3);
        issue(3'b001, 3'd6, 3'd1, 3'd2);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("mrst_valid", 32'(bus.res_valid), 32'd0);
        check("mrst_ready", 32'(bus.in_ready), 32'd1);
        check("mrst_data", bus.res_data, 32'd0);
        tick();
        check("mrst_hold", 32'(bus.res_valid), 32'd0);
        for (int r = 1; r < 8; r++) begin
            run("mrst_reg", 3'b000, 3'd0, 3'(r), 3'd0, 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end
endmodule
